// File: rtl/feistel_pkg.sv
// Shared types and bit-manipulation helpers for the iterative Feistel cipher.
// Helpers work on MAX_W-bit vectors with a runtime width argument so one
// function body serves every HALF_WIDTH. Callers zero-extend their operands
// and truncate the results with size casts.
package feistel_pkg;

    localparam int MAX_W = 64;
    localparam int IW    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reverse the low w bits of x.
    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) r[IW'(i)] = x[IW'(w - 1 - i)];
        return r;
    endfunction

    // Rotate the low w bits of x left by amt (taken mod w).
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int w, input int amt);
        logic [MAX_W-1:0] r;
        int a;
        r = '0;
        a = amt % w;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) r[IW'(i)] = x[IW'((i - a + w) % w)];
        return r;
    endfunction

    // Expansion of an h-bit half to 2h bits: {bitrev(R), rotl(R,1)}.
    function automatic logic [MAX_W-1:0] expand(input logic [MAX_W-1:0] r, input int h);
        return (bitrev(r, h) << h) | rotl(r, h, 1);
    endfunction

    // Round key for round idx; decrypt walks the encrypt schedule backwards.
    function automatic logic [MAX_W-1:0] round_key(input logic [MAX_W-1:0] key, input int w2,
                                                   input int idx, input logic dec,
                                                   input int rounds, input int key_rot);
        int step;
        step = dec ? (rounds - 1 - idx) : idx;
        return rotl(key, w2, (step * key_rot) % w2);
    endfunction

endpackage

// File: rtl/feistel_round.sv
// One combinational Feistel round: L' = R, R' = L ^ F(R, K).
// F = hi(E(R)^K) + lo(E(R)^K) + K[0], all mod 2^H.
module feistel_round
    import feistel_pkg::*;
#(
    parameter int HALF_WIDTH = 4
) (
    input  logic [HALF_WIDTH-1:0]   l,
    input  logic [HALF_WIDTH-1:0]   r,
    input  logic [2*HALF_WIDTH-1:0] k,
    output logic [HALF_WIDTH-1:0]   l_next,
    output logic [HALF_WIDTH-1:0]   r_next
);
    localparam int H  = HALF_WIDTH;
    localparam int W2 = 2 * HALF_WIDTH;

    logic [W2-1:0] e;
    logic [H-1:0]  f;

    // Round function; the carry out of the H-bit sum is dropped.
    always_comb begin
        e      = W2'(expand(MAX_W'(r), H)) ^ k;
        f      = e[W2-1:H] + e[H-1:0] + {{(H-1){1'b0}}, k[0]};
        l_next = r;
        r_next = l ^ f;
    end

endmodule

// File: rtl/feistel_cipher_iter.sv
// Iterative Feistel cipher: one round per clock, ROUNDS rounds per block,
// valid/ready on both sides. A single round instance is reused every RUN
// cycle; the round key is derived from the latched key and the round counter.
// HALF_WIDTH is limited to 32 by the package helper width.
module feistel_cipher_iter
    import feistel_pkg::*;
#(
    parameter int HALF_WIDTH = 4,
    parameter int ROUNDS     = 4,
    parameter int KEY_ROT    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic [2*HALF_WIDTH-1:0] number,
    input  logic [2*HALF_WIDTH-1:0] key,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*HALF_WIDTH-1:0] enc_number
);
    localparam int H  = HALF_WIDTH;
    localparam int W2 = 2 * HALF_WIDTH;
    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [H-1:0]  l_q, l_d, r_q, r_d;
    logic [W2-1:0] key_q, key_d;
    logic          mode_q, mode_d;
    logic [W2-1:0] enc_q, enc_d;
    logic          out_valid_q, out_valid_d;

    logic [W2-1:0] k_i;
    logic [H-1:0]  l_n, r_n;

    assign k_i = W2'(round_key(MAX_W'(key_q), W2, int'(cnt_q), mode_q, ROUNDS, KEY_ROT));

    feistel_round #(.HALF_WIDTH(H)) u_round (
        .l      (l_q),
        .r      (r_q),
        .k      (k_i),
        .l_next (l_n),
        .r_next (r_n)
    );

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign enc_number = enc_q;

    // Next-state: accept in IDLE, one round per RUN cycle, hold result in DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        key_d       = key_q;
        mode_d      = mode_q;
        enc_d       = enc_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    l_d     = number[W2-1:H];
                    r_d     = number[H-1:0];
                    key_d   = key;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                l_d = l_n;
                r_d = r_n;
                if (cnt_q == LAST) begin
                    // Final swap so decrypt is the same datapath with reversed keys.
                    enc_d       = {r_n, l_n};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight block.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            key_q       <= '0;
            mode_q      <= 1'b0;
            enc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            key_q       <= key_d;
            mode_q      <= mode_d;
            enc_q       <= enc_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_feistel_cipher_iter.sv
// Bench for feistel_cipher_iter: three parameterisations share one stimulus
// bus; sel picks which instance is driven and observed.
module tb_feistel_cipher_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mode, out_ready;
    logic [15:0] number, key;
    int          sel;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    logic       rdy0, v0, rdy1, v1, rdy2, v2;
    logic [7:0] n0, n1;
    logic [15:0] n2;
    logic       obs_rdy, obs_v;
    logic [15:0] obs_n;

    feistel_cipher_iter #(.HALF_WIDTH(4), .ROUNDS(1), .KEY_ROT(1)) u_r1 (
        .clock(clk), .reset(rst), .in_valid(in_valid && sel == 0), .in_ready(rdy0),
        .mode(mode), .number(number[7:0]), .key(key[7:0]), .out_valid(v0),
        .out_ready(out_ready && sel == 0), .enc_number(n0));

    feistel_cipher_iter u_def (
        .clock(clk), .reset(rst), .in_valid(in_valid && sel == 1), .in_ready(rdy1),
        .mode(mode), .number(number[7:0]), .key(key[7:0]), .out_valid(v1),
        .out_ready(out_ready && sel == 1), .enc_number(n1));

    feistel_cipher_iter #(.HALF_WIDTH(8), .ROUNDS(6), .KEY_ROT(3)) u_w (
        .clock(clk), .reset(rst), .in_valid(in_valid && sel == 2), .in_ready(rdy2),
        .mode(mode), .number(number), .key(key), .out_valid(v2),
        .out_ready(out_ready && sel == 2), .enc_number(n2));

    always_comb begin
        obs_rdy = rdy1; obs_v = v1; obs_n = {8'h00, n1};
        case (sel)
            0: begin obs_rdy = rdy0; obs_v = v0; obs_n = {8'h00, n0}; end
            2: begin obs_rdy = rdy2; obs_v = v2; obs_n = n2; end
            default: ;
        endcase
    end

    // ---------------- reference model (plain integer arithmetic) ----------
    function automatic int unsigned rotl_m(int unsigned x, int w, int a);
        int unsigned m;
        m = (32'd1 << w) - 1;
        a = a % w;
        if (a == 0) return x & m;
        return ((x << a) | ((x & m) >> (w - a))) & m;
    endfunction

    function automatic int unsigned model(bit dec, int unsigned num, int unsigned k,
                                          int h, int rounds, int kr);
        int unsigned m, l, r, ki, br, e, f, t;
        int idx;
        m = (32'd1 << h) - 1;
        l = (num >> h) & m;
        r = num & m;
        for (int i = 0; i < rounds; i++) begin
            idx = dec ? rounds - 1 - i : i;
            ki = rotl_m(k, 2 * h, (idx * kr) % (2 * h));
            br = 0;
            for (int b = 0; b < h; b++)
                if (((r >> b) & 1) != 0) br = br | (32'd1 << (h - 1 - b));
            e = ((br << h) | rotl_m(r, h, 1)) ^ ki;
            f = ((e >> h) + (e & m) + (ki & 1)) & m;
            t = l ^ f;
            l = r;
            r = t;
        end
        return (r << h) | l;
    endfunction

    // Push one block through the selected instance and pop its result.
    task automatic xfer(input bit m, input logic [15:0] num, input logic [15:0] k,
                        output logic [15:0] res, output int lat, output bit rdy_ok);
        int w;
        rdy_ok = 1'b1;
        w = 0;
        @(negedge clk);
        while (!obs_rdy && w < 50) begin @(negedge clk); w++; end
        mode = m; number = num; key = k; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!obs_v && lat < 50) begin
            if (obs_rdy) rdy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (obs_rdy) rdy_ok = 1'b0;
        res = obs_n;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_total++; if (obs_rdy !== 1'b1) $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, obs_rdy); else n_pass++;
            n_total++; if (obs_v !== 1'b0) $display("FAIL reset_out_valid sel=%0d got=%b exp=0", s, obs_v); else n_pass++;
            n_total++; if (obs_n !== 16'h0) $display("FAIL reset_enc sel=%0d got=%h exp=0", s, obs_n); else n_pass++;
        end
    endtask

    task automatic test_vectors_r1();
        logic [15:0] res;
        int lat;
        bit ok;
        sel = 0;
        xfer(1'b0, 16'h0046, 16'h0093, res, lat, ok);
        n_total++; if (res !== 16'h00B6) $display("FAIL r1_encrypt got=%h exp=00b6", res); else n_pass++;
        n_total++; if (lat !== 1) $display("FAIL r1_latency got=%0d exp=1", lat); else n_pass++;
        n_total++; if (ok !== 1'b1) $display("FAIL r1_in_ready_busy got=%b exp=1", ok); else n_pass++;
        xfer(1'b1, 16'h00B6, 16'h0093, res, lat, ok);
        n_total++; if (res !== 16'h0046) $display("FAIL r1_decrypt got=%h exp=0046", res); else n_pass++;
    endtask

    task automatic test_roundtrip_default();
        logic [15:0] c, p, x, k;
        int lat;
        bit ok;
        sel = 1;
        xfer(1'b0, 16'h00C9, 16'h00AC, c, lat, ok);
        n_total++; if (c !== 16'(model(0, 32'hC9, 32'hAC, 4, 4, 1))) $display("FAIL def_encrypt_c9 got=%h exp=%h", c, model(0, 32'hC9, 32'hAC, 4, 4, 1)); else n_pass++;
        n_total++; if (lat !== 4) $display("FAIL def_latency got=%0d exp=4", lat); else n_pass++;
        xfer(1'b1, c, 16'h00AC, p, lat, ok);
        n_total++; if (p !== 16'h00C9) $display("FAIL def_roundtrip_c9 got=%h exp=00c9", p); else n_pass++;
        for (int i = 0; i < 256; i++) begin
            x = 16'($urandom_range(0, 255));
            k = 16'($urandom_range(0, 255));
            xfer(1'b0, x, k, c, lat, ok);
            n_total++; if (c !== 16'(model(0, x, k, 4, 4, 1))) $display("FAIL def_rand_enc x=%h k=%h got=%h exp=%h", x, k, c, model(0, x, k, 4, 4, 1)); else n_pass++;
            n_total++; if (lat !== 4 || ok !== 1'b1) $display("FAIL def_rand_timing lat=%0d exp=4 rdy_ok=%b exp=1", lat, ok); else n_pass++;
            xfer(1'b1, c, k, p, lat, ok);
            n_total++; if (p !== x) $display("FAIL def_rand_rt x=%h k=%h got=%h exp=%h", x, k, p, x); else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [15:0] x, k, got, exp;
        int w;
        sel = 1;
        x = 16'($urandom_range(0, 255));
        k = 16'($urandom_range(0, 255));
        exp = 16'(model(0, x, k, 4, 4, 1));
        @(negedge clk);
        mode = 1'b0; number = x; key = k; in_valid = 1'b1;
        @(negedge clk);
        // keep in_valid high with different data: must be ignored
        number = ~x & 16'h00FF; key = ~k & 16'h00FF; mode = 1'b1;
        w = 0;
        while (!obs_v && w < 50) begin
            n_total++; if (obs_rdy !== 1'b0) $display("FAIL stall_in_ready_run got=%b exp=0", obs_rdy); else n_pass++;
            @(negedge clk);
            w++;
        end
        n_total++; if (w !== 4) $display("FAIL stall_latency got=%0d exp=4", w); else n_pass++;
        got = obs_n;
        n_total++; if (got !== exp) $display("FAIL stall_result got=%h exp=%h", got, exp); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (obs_v !== 1'b1 || obs_n !== exp || obs_rdy !== 1'b0)
                $display("FAIL stall_hold cyc=%0d valid=%b enc=%h rdy=%b exp valid=1 enc=%h rdy=0", i, obs_v, obs_n, obs_rdy, exp);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        n_total++; if (obs_v !== 1'b0 || obs_rdy !== 1'b1 || obs_n !== exp)
            $display("FAIL stall_release valid=%b rdy=%b enc=%h exp valid=0 rdy=1 enc=%h", obs_v, obs_rdy, obs_n, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] x, k, res;
        int lat;
        bit ok;
        sel = 1;
        @(negedge clk);
        mode = 1'b0; number = 16'h005A; key = 16'h0033; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (obs_v !== 1'b0 || obs_n !== 16'h0 || obs_rdy !== 1'b1)
            $display("FAIL midrun_reset valid=%b enc=%h rdy=%b exp valid=0 enc=0000 rdy=1", obs_v, obs_n, obs_rdy);
        else n_pass++;
        x = 16'($urandom_range(0, 255));
        k = 16'($urandom_range(0, 255));
        xfer(1'b0, x, k, res, lat, ok);
        n_total++; if (res !== 16'(model(0, x, k, 4, 4, 1)) || lat !== 4)
            $display("FAIL midrun_after got=%h lat=%0d exp=%h lat=4", res, lat, model(0, x, k, 4, 4, 1));
        else n_pass++;
    endtask

    task automatic test_wide();
        logic [15:0] x, k, c, p;
        int lat;
        bit ok;
        sel = 2;
        for (int i = 0; i < 64; i++) begin
            x = 16'($urandom);
            k = 16'($urandom);
            xfer(1'b0, x, k, c, lat, ok);
            n_total++; if (c !== 16'(model(0, x, k, 8, 6, 3))) $display("FAIL wide_enc x=%h k=%h got=%h exp=%h", x, k, c, model(0, x, k, 8, 6, 3)); else n_pass++;
            n_total++; if (lat !== 6 || ok !== 1'b1) $display("FAIL wide_timing lat=%0d exp=6 rdy_ok=%b exp=1", lat, ok); else n_pass++;
            xfer(1'b1, c, k, p, lat, ok);
            n_total++; if (p !== x) $display("FAIL wide_rt x=%h k=%h got=%h exp=%h", x, k, p, x); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0;
        number = '0; key = '0; sel = 1;
        test_reset();
        test_vectors_r1();
        test_roundtrip_default();
        test_stall();
        test_reset_mid_run();
        test_wide();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
